// File: rtl/rr_arbiter8_32.sv
// Round-robin 8-to-1 word arbiter with a registered output stage and valid/ready hand-off.
// Each requester gets a one-cycle ack when its word is captured into the output register.
module rr_arbiter8_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       req,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic [WIDTH-1:0] in5,
  input  logic [WIDTH-1:0] in6,
  input  logic [WIDTH-1:0] in7,
  output logic [7:0]       ack,
  output logic             s2,
  output logic             s1,
  output logic             s0,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready
);

  // state | meaning
  // IDLE  | output register empty
  // HOLD  | output register holds a word not yet accepted
  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [2:0]       sel_q, sel_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic [7:0]       ack_q, ack_d;
  logic [7:0]       ereq;
  logic [2:0]       win;
  logic             found;
  logic             cap;
  logic [WIDTH-1:0] words [8];

  assign words[0] = in0;
  assign words[1] = in1;
  assign words[2] = in2;
  assign words[3] = in3;
  assign words[4] = in4;
  assign words[5] = in5;
  assign words[6] = in6;
  assign words[7] = in7;

  // A requester in its ack cycle is masked so it cannot be granted twice.
  assign ereq = req & ~ack_q;

  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (!found && ereq[ptr_q + 3'(k)]) begin
        win   = ptr_q + 3'(k);
        found = 1'b1;
      end
    end
  end

  assign cap = found && ((state_q == IDLE) || out_ready);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    out_d   = out_q;
    valid_d = valid_q;
    ack_d   = '0;
    if (cap) begin
      out_d   = words[win];
      sel_d   = win;
      ack_d   = 8'd1 << win;
      valid_d = 1'b1;
      ptr_d   = win + 3'd1;
      state_d = HOLD;
    end else if (state_q == HOLD && out_ready) begin
      valid_d = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
    end
  end

  assign ack       = ack_q;
  assign {s2, s1, s0} = sel_q;
  assign out       = out_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter8_32.sv
// Bench for rr_arbiter8_32: directed scenarios plus randomized requesters,
// all checked against a transaction-level round-robin model.
module tb_rr_arbiter8_32;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  req;
  logic [31:0] din [8];
  logic [7:0]  ack;
  logic        s2, s1, s0;
  logic [31:0] dout;
  logic        out_valid;
  logic        out_ready;

  always #5 clk = ~clk;

  rr_arbiter8_32 #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .req(req),
    .in0(din[0]), .in1(din[1]), .in2(din[2]), .in3(din[3]),
    .in4(din[4]), .in5(din[5]), .in6(din[6]), .in7(din[7]),
    .ack(ack), .s2(s2), .s1(s1), .s0(s0),
    .out(dout), .out_valid(out_valid), .out_ready(out_ready)
  );

  // reference model: "full" flag, next search start, held word/index, ack vector
  bit          m_full;
  int          m_ptr;
  logic [31:0] m_out;
  int          m_sel;
  logic [7:0]  m_ack;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_full = 0; m_ptr = 0; m_out = '0; m_sel = 0; m_ack = '0;
  endtask

  task automatic model_edge();
    logic [7:0] e;
    bit         done;
    int         idx;
    e    = req & ~m_ack;
    done = 0;
    if ((!m_full || out_ready) && e != 0) begin
      for (int k = 0; k < 8; k++) begin
        idx = (m_ptr + k) % 8;
        if (!done && e[idx]) begin
          done   = 1;
          m_out  = din[idx];
          m_sel  = idx;
          m_ack  = 8'(1 << idx);
          m_full = 1;
          m_ptr  = (idx + 1) % 8;
        end
      end
    end else begin
      m_ack = '0;
      if (m_full && out_ready) m_full = 0;
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_out"},   dout,                    m_out);
    chk({tag, "_sel"},   {29'd0, s2, s1, s0},     32'(m_sel));
    chk({tag, "_valid"}, {31'd0, out_valid},      {31'd0, m_full});
    chk({tag, "_ack"},   {24'd0, ack},            {24'd0, m_ack});
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req   = '0;
    #1;
    model_reset();
    compare_all("rst");
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic prev3;

  initial begin
    reset = 1'b1;
    req = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) din[i] = '0;
    model_reset();
    #2;
    chk("por_out", dout, 32'h0);
    chk("por_valid", {31'd0, out_valid}, 32'h0);
    chk("por_ack", {24'd0, ack}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // single request, latency one cycle, then drop
    req = 8'h01; din[0] = 32'h1111_1111; out_ready = 1'b1;
    step("t1a");
    chk("t1_out", dout, 32'h1111_1111);
    chk("t1_ack", {24'd0, ack}, 32'h01);
    chk("t1_sel", {29'd0, s2, s1, s0}, 32'd0);
    req = 8'h00;
    step("t1b");
    chk("t1_valid_drop", {31'd0, out_valid}, 32'h0);
    chk("t1_ack_drop", {24'd0, ack}, 32'h0);

    // all eight requesting: back-to-back walk 0..7,0
    do_reset();
    for (int i = 0; i < 8; i++) din[i] = 32'(i);
    req = 8'hFF; out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step("t2");
      chk("t2_seq_out", dout, 32'(k % 8));
      chk("t2_seq_ack", {24'd0, ack}, 32'(1 << (k % 8)));
    end

    // wrap-around from ptr=3
    do_reset();
    req = 8'h04; din[2] = 32'hA2; din[7] = 32'hA7; out_ready = 1'b1;
    step("t3a");
    req = 8'h84;
    step("t3b");
    chk("t3_first", {29'd0, s2, s1, s0}, 32'd7);
    step("t3c");
    chk("t3_second", {29'd0, s2, s1, s0}, 32'd2);

    // back-pressure holds the word and blocks acks
    do_reset();
    req = 8'h20; din[5] = 32'hDEAD_BEEF; din[0] = 32'h0000_00A0; out_ready = 1'b1;
    step("t4a");
    req = 8'h01; out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step("t4h");
      chk("t4_hold_out", dout, 32'hDEAD_BEEF);
      chk("t4_hold_sel", {29'd0, s2, s1, s0}, 32'd5);
      chk("t4_hold_valid", {31'd0, out_valid}, 32'h1);
      chk("t4_hold_ack", {24'd0, ack}, 32'h0);
    end
    out_ready = 1'b1;
    step("t4r");
    chk("t4_release_ack", {24'd0, ack}, 32'h01);
    chk("t4_release_out", dout, 32'h0000_00A0);

    // single requester: one word every two cycles
    do_reset();
    req = 8'h08; din[3] = 32'h3333_0003; out_ready = 1'b1;
    prev3 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step("t5");
      chk("t5_ack3", {31'd0, ack[3]}, {31'd0, (k % 2 == 0)});
      chk("t5_no_consec", {31'd0, prev3 & ack[3]}, 32'h0);
      prev3 = ack[3];
    end

    // asynchronous reset mid-HOLD
    do_reset();
    req = 8'h20; din[5] = 32'h5555_0005; din[0] = 32'hC0; din[7] = 32'hC7; out_ready = 1'b0;
    step("t6a");
    #3;
    reset = 1'b1;
    #1;
    chk("t6_async_out", dout, 32'h0);
    chk("t6_async_sel", {29'd0, s2, s1, s0}, 32'h0);
    chk("t6_async_valid", {31'd0, out_valid}, 32'h0);
    chk("t6_async_ack", {24'd0, ack}, 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    req = 8'h81; out_ready = 1'b1;
    step("t6b");
    chk("t6_restart_sel", {29'd0, s2, s1, s0}, 32'd0);

    // randomized requesters obeying the hold-until-ack protocol
    do_reset();
    for (int k = 0; k < 2000; k++) begin
      for (int i = 0; i < 8; i++) begin
        if (m_ack[i]) begin
          if ($urandom % 2 == 0) req[i] = 1'b0;
          else din[i] = $urandom;
        end else if (!req[i] && ($urandom % 3 == 0)) begin
          req[i] = 1'b1;
          din[i] = $urandom;
        end
      end
      out_ready = ($urandom % 4) != 0;
      step("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8_32.md
# rr_arbiter8_32

Round-robin arbiter and sequencer for the 8-to-1 32-bit word mux in the MIPS-lite datapath. Up to eight requesters share one 32-bit output path. The block picks a winner fairly and drives the mux select lines `s2,s1,s0`. It captures the selected word into an output register and hands that word to a single consumer over a valid/ready handshake. Each requester gets a one-cycle `ack` when its word has been taken.

## Interface
Parameters:
- `WIDTH`, 32: data width of every input word and of `out`.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high; clears all state immediately.
- `req`  input  8  `req[i]` = requester i is presenting a valid word on `in_i`.
- `in0`..`in7`  input  WIDTH each  requester data words.
- `ack`  output  8  one-hot; `ack[i]` is high for exactly one cycle after requester i's word is captured.
- `s2`, `s1`, `s0`  output  1 each  registered mux select {s2,s1,s0} = index of the word currently held in `out`.
- `out`  output  WIDTH  registered output word.
- `out_valid`  output  1  `out` holds a word not yet accepted.
- `out_ready`  input  1  consumer accepts `out` at an edge where `out_valid && out_ready`.

## Operation
- State: `IDLE` (output register empty) and `HOLD` (output register full). Internal 3-bit round-robin pointer `ptr`.
- Effective request vector `ereq = req & ~ack`. A requester whose `ack` is high this cycle is masked, so it can drop `req` in its ack cycle without being granted twice.
- Winner `w` is the first index with `ereq[w]=1`, searching `ptr, ptr+1, ..., ptr+7` mod 8.
- Capture is enabled when (state=`IDLE`) or (state=`HOLD` and `out_ready`), and `ereq != 0`.
- On a capture edge:
  - `out <= in_w` and `{s2,s1,s0} <= w`.
  - `ack <= onehot(w)` and `out_valid <= 1`.
  - `ptr <= (w+1) mod 8`, state `HOLD`.
- On an edge in `HOLD` with `out_ready=1` and `ereq=0`: `out_valid <= 0`, state `IDLE`. `out` and the select keep their last values.
- On an edge in `HOLD` with `out_ready=0`: `out`, the select, `out_valid` and `ptr` are held, and no requester is acked. Requesters must keep `req` and data stable until acked.
- On any edge with no capture: `ack <= 0`.
- `ptr` changes only on a capture, and wraps from 7 to 0.
- Requester protocol: requester i holds `req[i]` and `in_i` stable until it sees `ack[i]`. It then deasserts `req[i]` or presents its next word.

## Timing
- Reset values: state `IDLE`, `ptr`=0, `out`=0, `{s2,s1,s0}`=000, `out_valid`=0, `ack`=0.
- Latency: `req[i]` rises in cycle 0 while `IDLE` → `out_valid`=1, `out`=`in_i` and `ack[i]`=1 in cycle 1.
- Throughput:
  - With `out_ready` held high and two or more requesters active: one word per cycle, back-to-back, with no idle cycle between words.
  - With a single requester: one word every 2 cycles, because of the ack-cycle mask.
- `ack` is never high for more than one requester or for more than one cycle per captured word.
- Reset asserted mid-operation clears the held word without acking the consumer. No `ack` is re-issued, and arbitration restarts from `ptr`=0.
- All outputs are driven from flops; no combinational path from `req` or `out_ready` to any output.

## Test plan
- Reset, then `req`=8'b0000_0001 with `in0`=32'h1111_1111 and `out_ready`=1 → cycle 1: `out`=32'h1111_1111, select 000, `ack`=8'h01, `out_valid`=1. Cycle 2, with `req` dropped: `out_valid`=0, `ack`=0.
- `req`=8'hFF held (`in_i`=i) with `out_ready`=1, and each requester re-requesting after its ack → `out` sequence 0,1,2,...,7,0 on consecutive cycles, and `ack` walks one-hot 01,02,04,...,80,01.
- `req`=8'b1000_0100 with `ptr`=3 → first grant is index 7 (select 111), next is index 2 (select 010). This checks wrap-around.
- `out_ready`=0 for 5 cycles after a capture from index 5 (`in5`=32'hDEAD_BEEF) → `out`, select 101 and `out_valid`=1 are held, and no further `ack` is issued. Raise `out_ready` → next pending requester is captured on that edge.
- Single requester 3 re-requesting continuously with `out_ready`=1 → `ack[3]` pulses every 2nd cycle and is never high on two consecutive cycles.
- Assert `reset` asynchronously mid-`HOLD` → `out_valid`, `ack`, `out` and select go to 0 immediately, with no clock edge required. After release, the first grant searches from index 0.
